// File: rtl/counter_32_pkg.sv
// Shared types and constants for the 32-bit counter monitor.
package counter_32_pkg;

    // Classification of one observed count transition.
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        INC     = 3'd1,
        DEC     = 3'd2,
        WRAP_UP = 3'd3,
        WRAP_DN = 3'd4,
        JUMP    = 3'd5
    } step_e;

    // Inferred direction of the observed counter.
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        UP     = 2'd2,
        DOWN   = 2'd3
    } mon_state_e;

    localparam logic [31:0] MAX_COUNT = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN_COUNT = 32'h0000_0000;

endpackage

// File: rtl/counter_step_classify.sv
// Combinational classifier: compares the previous and current count samples
// and names the transition between them.
module counter_step_classify
    import counter_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output step_e            step
);

    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] all_ones;
    logic [WIDTH-1:0] one;

    assign all_ones = '1;
    assign one      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Modular delta decides the step; the endpoint of prev separates wraps from plain steps.
    always_comb begin
        delta = cur - prev;
        step  = HOLD;
        if (delta == '0) begin
            step = HOLD;
        end else if (delta == one) begin
            step = (prev == all_ones) ? WRAP_UP : INC;
        end else if (delta == all_ones) begin
            step = (prev == '0) ? WRAP_DN : DEC;
        end else begin
            step = JUMP;
        end
    end

endmodule

// File: rtl/counter_monitor_32.sv
// Receive-side observer for an up/down/load counter bus: classifies each
// sampled transition, tracks inferred direction and keeps statistics.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   UNSYNC | no reference sample yet; next en sample only captures prev
//   SYNC   | reference held, direction unknown (after first sample/JUMP)
//   UP     | last moving step was INC or WRAP_UP
//   DOWN   | last moving step was DEC or WRAP_DN
module counter_monitor_32
    import counter_32_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              exp_mode,
    input  logic              chk_en,
    input  logic              clr,
    output logic [2:0]        step,
    output logic              step_vld,
    output logic              locked,
    output logic              dir_up,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] jump_count,
    output logic              err_sticky
);

    mon_state_e        state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    step_e             step_q, step_d, step_cls;
    logic              step_vld_q, step_vld_d;
    logic [STAT_W-1:0] wrap_q, wrap_d;
    logic [STAT_W-1:0] jump_q, jump_d;
    logic              err_q, err_d;
    logic              is_up_step;
    logic              is_dn_step;

    counter_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev (prev_q),
        .cur  (count_in),
        .step (step_cls)
    );

    assign is_up_step = (step_cls == INC) || (step_cls == WRAP_UP);
    assign is_dn_step = (step_cls == DEC) || (step_cls == WRAP_DN);

    // Next-state: FSM, step capture, saturating statistics and sticky check; clr overrides stats.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        step_d     = step_q;
        step_vld_d = 1'b0;
        wrap_d     = wrap_q;
        jump_d     = jump_q;
        err_d      = err_q;

        if (en) begin
            prev_d = count_in;
            if (state_q == UNSYNC) begin
                state_d = SYNC;
            end else begin
                step_d     = step_cls;
                step_vld_d = 1'b1;
                if (is_up_step) begin
                    state_d = UP;
                end else if (is_dn_step) begin
                    state_d = DOWN;
                end else if (step_cls == JUMP) begin
                    state_d = SYNC;
                    if (jump_q != '1) begin
                        jump_d = jump_q + 1'b1;
                    end
                end
                if ((step_cls == WRAP_UP || step_cls == WRAP_DN) && (wrap_q != '1)) begin
                    wrap_d = wrap_q + 1'b1;
                end
                if (chk_en && ((is_up_step && !exp_mode) || (is_dn_step && exp_mode))) begin
                    err_d = 1'b1;
                end
            end
        end

        if (clr) begin
            wrap_d = '0;
            jump_d = '0;
            err_d  = 1'b0;
        end
    end

    // Registers with synchronous active-low reset discarding all history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= UNSYNC;
            prev_q     <= '0;
            step_q     <= HOLD;
            step_vld_q <= 1'b0;
            wrap_q     <= '0;
            jump_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            step_vld_q <= step_vld_d;
            wrap_q     <= wrap_d;
            jump_q     <= jump_d;
            err_q      <= err_d;
        end
    end

    assign step       = step_q;
    assign step_vld   = step_vld_q;
    assign locked     = (state_q == UP) || (state_q == DOWN);
    assign dir_up     = (state_q == UP);
    assign wrap_count = wrap_q;
    assign jump_count = jump_q;
    assign err_sticky = err_q;

endmodule
